// File: rtl/playlist_pkg.sv
// Shared types for the playlist controller: FSM state encoding and the
// same-edge input priority used to pick one event per cycle.
package playlist_pkg;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        PLAYING  = 2'd1,
        SWITCH_P = 2'd2,
        SWITCH_R = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_NEXT = 3'd1,
        EV_PREV = 3'd2,
        EV_DONE = 3'd3,
        EV_PLAY = 3'd4
    } event_t;

    // Priority next > prev > song_done > play; lower events on the same edge are dropped.
    function automatic event_t pick_event(input logic next_b, input logic prev_b,
                                          input logic done, input logic play_b);
        event_t ev;
        ev = EV_NONE;
        if (next_b)      ev = EV_NEXT;
        else if (prev_b) ev = EV_PREV;
        else if (done)   ev = EV_DONE;
        else if (play_b) ev = EV_PLAY;
        return ev;
    endfunction

endpackage

// File: rtl/song_index_counter.sv
// Registered index counter with modulo-NUM_SONGS wrap in both directions.
module song_index_counter #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              load_zero,
    output logic [SONG_W-1:0] index
);

    localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

    always_ff @(posedge clk) begin
        if (reset || load_zero)
            index <= '0;
        else if (inc)
            index <= (index == LAST) ? '0 : index + SONG_W'(1);
        else if (dec)
            index <= (index == '0) ? LAST : index - SONG_W'(1);
    end

endmodule

// File: rtl/playlist_ctrl.sv
// Playback controller: play/pause, next/prev, repeat-one and auto-advance,
// emitting a one-cycle restart pulse to the song reader on every song switch.
module playlist_ctrl
    import playlist_pkg::*;
#(
    parameter int NUM_SONGS    = 4,
    parameter int SONG_W       = 2,
    parameter int AUTO_ADVANCE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              repeat_button,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] current_song,
    output logic              repeat_mode
);

    state_t state, next_state;
    event_t ev;
    logic   inc, dec;

    always_comb begin
        next_state = state;
        inc        = 1'b0;
        dec        = 1'b0;
        ev         = pick_event(next_button, prev_button, song_done, play_button);
        case (state)
            PAUSED: begin
                case (ev)
                    EV_NEXT: begin inc = 1'b1; next_state = SWITCH_P; end
                    EV_PREV: begin dec = 1'b1; next_state = SWITCH_P; end
                    EV_PLAY: next_state = PLAYING;
                    default: ;
                endcase
            end
            PLAYING: begin
                case (ev)
                    EV_NEXT: begin inc = 1'b1; next_state = SWITCH_P; end
                    EV_PREV: begin dec = 1'b1; next_state = SWITCH_P; end
                    EV_PLAY: next_state = PAUSED;
                    EV_DONE: begin
                        if (repeat_mode) begin
                            next_state = SWITCH_R;
                        end else begin
                            inc        = 1'b1;
                            next_state = (AUTO_ADVANCE != 0) ? SWITCH_R : SWITCH_P;
                        end
                    end
                    default: ;
                endcase
            end
            SWITCH_P: next_state = PAUSED;
            SWITCH_R: next_state = PLAYING;
            default:  next_state = PAUSED;
        endcase
    end

    // Outputs are decoded from next_state so they update on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PAUSED;
            play         <= 1'b0;
            reset_player <= 1'b0;
            repeat_mode  <= 1'b0;
        end else begin
            state        <= next_state;
            play         <= (next_state == PLAYING);
            reset_player <= (next_state == SWITCH_P) || (next_state == SWITCH_R);
            if (repeat_button)
                repeat_mode <= ~repeat_mode;
        end
    end

    song_index_counter #(
        .NUM_SONGS(NUM_SONGS),
        .SONG_W   (SONG_W)
    ) u_index (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc),
        .dec      (dec),
        .load_zero(1'b0),
        .index    (current_song)
    );

endmodule

// File: tb/tb_playlist_ctrl.sv
// Bench for playlist_ctrl: two instances (auto-advance on/off) share inputs and
// are compared every cycle against an event-level model, plus directed checks.
module tb_playlist_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset, play_button, next_button, prev_button, repeat_button, song_done;
    logic       play_a, rp_a, rm_a, play_b, rp_b, rm_b;
    logic [1:0] song_a, song_b;

    int checks = 0;
    int errors = 0;

    // Model: per instance, playing flag, song, repeat, pending restart pulse and
    // whether playback resumes after that pulse. Index 0 = auto-advance, 1 = pause.
    int m_play[2], m_song[2], m_rep[2], m_pulse[2], m_resume[2];
    int aa[2] = '{1, 0};

    always #5 clk = ~clk;

    playlist_ctrl #(.NUM_SONGS(N), .SONG_W(2), .AUTO_ADVANCE(1)) dut_a (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .prev_button(prev_button), .repeat_button(repeat_button), .song_done(song_done),
        .play(play_a), .reset_player(rp_a), .current_song(song_a), .repeat_mode(rm_a));

    playlist_ctrl #(.NUM_SONGS(N), .SONG_W(2), .AUTO_ADVANCE(0)) dut_b (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .prev_button(prev_button), .repeat_button(repeat_button), .song_done(song_done),
        .play(play_b), .reset_player(rp_b), .current_song(song_b), .repeat_mode(rm_b));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int i, input bit nb, input bit pb, input bit rb,
                         input bit d, input bit pl, input bit rst);
        int rep_next;
        if (rst) begin
            m_play[i] = 0; m_song[i] = 0; m_rep[i] = 0; m_pulse[i] = 0; m_resume[i] = 0;
        end else begin
            rep_next = m_rep[i] ^ int'(rb);
            if (m_pulse[i] != 0) begin
                m_pulse[i] = 0;
                m_play[i]  = m_resume[i];
            end else if (nb) begin
                m_song[i] = (m_song[i] + 1) % N;
                m_pulse[i] = 1; m_resume[i] = 0; m_play[i] = 0;
            end else if (pb) begin
                m_song[i] = (m_song[i] + N - 1) % N;
                m_pulse[i] = 1; m_resume[i] = 0; m_play[i] = 0;
            end else if (d) begin
                if (m_play[i] != 0) begin
                    if (m_rep[i] == 0) m_song[i] = (m_song[i] + 1) % N;
                    m_resume[i] = (m_rep[i] != 0) ? 1 : aa[i];
                    m_pulse[i] = 1; m_play[i] = 0;
                end
            end else if (pl) begin
                m_play[i] = (m_play[i] != 0) ? 0 : 1;
            end
            m_rep[i] = rep_next;
        end
    endtask

    // One clock: drive at negedge, update model, sample 1 time unit after posedge.
    task automatic step(input bit nb, input bit pb, input bit rb, input bit d,
                        input bit pl, input bit rst);
        @(negedge clk);
        next_button = nb; prev_button = pb; repeat_button = rb;
        song_done = d; play_button = pl; reset = rst;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model(i, nb, pb, rb, d, pl, rst);
        #1;
        chk("a.play",  int'(play_a), m_play[0]);
        chk("a.rp",    int'(rp_a),   m_pulse[0]);
        chk("a.song",  int'(song_a), m_song[0]);
        chk("a.rep",   int'(rm_a),   m_rep[0]);
        chk("b.play",  int'(play_b), m_play[1]);
        chk("b.rp",    int'(rp_b),   m_pulse[1]);
        chk("b.song",  int'(song_b), m_song[1]);
        chk("b.rep",   int'(rm_b),   m_rep[1]);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1; play_button = 0; next_button = 0; prev_button = 0;
        repeat_button = 0; song_done = 0;

        // Reset held 4 cycles, then play
        repeat (4) do_reset();
        chk("rst.play", int'(play_a), 0);
        chk("rst.song", int'(song_a), 0);
        chk("rst.rep",  int'(rm_a),   0);
        chk("rst.rp",   int'(rp_a),   0);
        step(0, 0, 0, 0, 1, 0);
        chk("play.on", int'(play_a), 1);

        // Song 2 ends while playing: wrap to 0, resume (a) / pause (b)
        step(1, 0, 0, 0, 0, 0); idle();
        step(1, 0, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 1, 0);
        chk("s2.play", int'(play_a), 1);
        chk("s2.song", int'(song_a), 2);
        step(0, 0, 0, 1, 0, 0);
        chk("wrap.rp",   int'(rp_a),   1);
        chk("wrap.play", int'(play_a), 0);
        chk("wrap.song", int'(song_a), 0);
        chk("aa0.song",  int'(song_b), 0);
        idle();
        chk("wrap.resume", int'(play_a), 1);
        chk("aa0.paused",  int'(play_b), 0);
        chk("wrap.rp_end", int'(rp_a),   0);

        // Prev from song 0 wraps to 2, then next walks 0,1,2
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        chk("prev.song", int'(song_a), 2);
        chk("prev.rp",   int'(rp_a),   1);
        chk("prev.play", int'(play_a), 0);
        idle();
        chk("prev.rp_end", int'(rp_a), 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0, 0);
            chk("next.walk", int'(song_a), k);
            idle();
        end

        // Repeat-one restarts the same song
        do_reset();
        step(1, 0, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("rep.on", int'(rm_a), 1);
        step(0, 0, 0, 1, 0, 0);
        chk("rep.song", int'(song_a), 1);
        chk("rep.rp",   int'(rp_a),   1);
        chk("rep.bsong", int'(song_b), 1);
        idle();
        chk("rep.resume",  int'(play_a), 1);
        chk("rep.bresume", int'(play_b), 1);
        step(0, 0, 1, 0, 0, 0);
        chk("rep.off", int'(rm_a), 0);

        // Same-edge next+play+done: one increment, ends paused
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        chk("multi.song", int'(song_a), 1);
        chk("multi.rp",   int'(rp_a),   1);
        idle();
        chk("multi.play", int'(play_a), 0);
        chk("multi.song2", int'(song_a), 1);

        // Reset during the restart cycle
        do_reset();
        step(1, 0, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("aa0.s1done", int'(song_b), 2);
        chk("aa0.play",   int'(play_b), 0);
        chk("midsw.rp",   int'(rp_a),   1);
        do_reset();
        chk("midsw.play", int'(play_a), 0);
        chk("midsw.rp0",  int'(rp_a),   0);
        chk("midsw.song", int'(song_a), 0);
        chk("midsw.brp",  int'(rp_b),   0);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            bit nb, pb, rb, d, pl, rst;
            nb  = ($urandom_range(0, 9) == 0);
            pb  = ($urandom_range(0, 9) == 0);
            rb  = ($urandom_range(0, 11) == 0);
            d   = ($urandom_range(0, 5) == 0);
            pl  = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 99) == 0);
            if (d) pl = 1'b0;
            step(nb, pb, rb, d, pl, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
